// File: rtl/sdram_mem_scheduler.sv
// rtl/sdram_mem_scheduler.sv - circular sample log scheduler over a busy-handshake SDRAM interface
module sdram_mem_scheduler #(
  parameter int MAX_WORDS = 16777216,
  parameter int ACCEPT_TO = 8,
  parameter int OP_TO     = 32
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET,
  input  logic        WR_STB,
  input  logic [15:0] WR_DATA,
  output logic        WR_READY,
  input  logic        RD_STB,
  output logic        RD_READY,
  output logic [15:0] RD_DATA,
  output logic        RD_VALID,
  output logic [1:0]  SD_CMD,
  output logic [1:0]  SD_BANK,
  output logic [12:0] SD_ROW,
  output logic [8:0]  SD_COL,
  output logic [15:0] SD_DIN,
  input  logic        SD_STATUS,
  input  logic [15:0] SD_DOUT,
  output logic        MEM_READY,
  output logic [24:0] COUNT,
  output logic        OVERFLOW,
  output logic        ERR
);

  localparam logic [24:0] MAX_CNT  = 25'(MAX_WORDS);
  localparam logic [23:0] LAST_PTR = 24'(MAX_WORDS - 1);
  localparam logic [15:0] ACC_LAST = 16'(ACCEPT_TO - 1);
  localparam logic [15:0] OP_LAST  = 16'(OP_TO - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_BUSY, S_DONE, S_FAIL} state_t;

  state_t      state, next_state;
  logic [23:0] wr_ptr, rd_ptr, sel_ptr;
  logic [15:0] wr_data, tmr;
  logic        wr_pend, rd_pend, seen_hi, serve_wr, last_wr;
  logic        full, empty, drop_full, wr_ok, rd_ok, choose_wr, start;
  logic        acc_to, op_to, clr_wr, clr_rd;

  function automatic logic [23:0] next_ptr(input logic [23:0] p);
    return (p == LAST_PTR) ? 24'd0 : p + 24'd1;
  endfunction

  assign full      = (COUNT == MAX_CNT);
  assign empty     = (COUNT == 25'd0);
  assign drop_full = (state == S_IDLE) && wr_pend && full;
  assign wr_ok     = wr_pend && !full;
  assign rd_ok     = rd_pend && !empty;
  // On a tie the side that was not served last goes first.
  assign choose_wr = wr_ok && (!rd_ok || !last_wr);
  assign start     = (state == S_IDLE) && !drop_full && (wr_ok || rd_ok);
  assign sel_ptr   = choose_wr ? wr_ptr : rd_ptr;
  assign acc_to    = (tmr == ACC_LAST);
  assign op_to     = (tmr == OP_LAST);
  assign clr_wr    = drop_full || (((state == S_DONE) || (state == S_FAIL)) && serve_wr);
  assign clr_rd    = ((state == S_DONE) || (state == S_FAIL)) && !serve_wr;
  assign WR_READY  = MEM_READY & ~wr_pend;
  assign RD_READY  = MEM_READY & ~rd_pend;

  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) state <= S_INIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INIT:  if (seen_hi && !SD_STATUS) next_state = S_IDLE;
      S_IDLE:  if (start) next_state = S_ISSUE;
      S_ISSUE: if (SD_STATUS) next_state = S_BUSY;
               else if (acc_to) next_state = S_FAIL;
      S_BUSY:  if (!SD_STATUS) next_state = S_DONE;
               else if (op_to) next_state = S_FAIL;
      S_DONE:  next_state = S_IDLE;
      S_FAIL:  next_state = S_IDLE;
      default: next_state = S_INIT;
    endcase
  end

  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      MEM_READY <= 1'b0; COUNT <= '0; OVERFLOW <= 1'b0; ERR <= 1'b0;
      RD_DATA <= '0; RD_VALID <= 1'b0; SD_CMD <= '0; SD_BANK <= '0;
      SD_ROW <= '0; SD_COL <= '0; SD_DIN <= '0; wr_ptr <= '0; rd_ptr <= '0;
      wr_pend <= 1'b0; rd_pend <= 1'b0; wr_data <= '0; seen_hi <= 1'b0;
      serve_wr <= 1'b0; last_wr <= 1'b0; tmr <= '0;
    end else begin
      RD_VALID <= 1'b0;
      case (state)
        S_INIT: begin
          if (SD_STATUS) seen_hi <= 1'b1;
          if (seen_hi && !SD_STATUS) MEM_READY <= 1'b1;
        end
        S_IDLE: begin
          if (drop_full) OVERFLOW <= 1'b1;
          else if (start) begin
            serve_wr <= choose_wr;
            SD_CMD   <= choose_wr ? 2'd2 : 2'd1;
            SD_BANK  <= sel_ptr[23:22];
            SD_ROW   <= sel_ptr[21:9];
            SD_COL   <= sel_ptr[8:0];
            if (choose_wr) SD_DIN <= wr_data;
            tmr      <= '0;
          end
        end
        S_ISSUE: begin
          if (SD_STATUS) begin
            SD_CMD <= 2'd0;
            tmr    <= '0;
          end else begin
            tmr <= tmr + 16'd1;
            if (acc_to) SD_CMD <= 2'd0;
          end
        end
        S_BUSY: tmr <= tmr + 16'd1;
        S_DONE: begin
          if (serve_wr) begin
            wr_ptr <= next_ptr(wr_ptr);
            COUNT  <= COUNT + 25'd1;
          end else begin
            RD_DATA  <= SD_DOUT;
            RD_VALID <= 1'b1;
            rd_ptr   <= next_ptr(rd_ptr);
            COUNT    <= COUNT - 25'd1;
          end
          last_wr <= serve_wr;
        end
        S_FAIL: begin
          SD_CMD <= 2'd0;
          ERR    <= 1'b1;
        end
        default: ;
      endcase

      // A strobe landing on the cycle its pend flag clears is taken as a new request.
      if (clr_wr) wr_pend <= 1'b0;
      if (MEM_READY && WR_STB) begin
        if (!wr_pend || clr_wr) begin
          wr_pend <= 1'b1;
          wr_data <= WR_DATA;
        end else begin
          OVERFLOW <= 1'b1;
        end
      end
      if (clr_rd) rd_pend <= 1'b0;
      if (MEM_READY && RD_STB && (!rd_pend || clr_rd)) rd_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_mem_scheduler.sv
// tb/tb_sdram_mem_scheduler.sv - directed self-checking bench for sdram_mem_scheduler
module tb_sdram_mem_scheduler;

  logic        CLK_48MHZ, RESET, WR_STB, RD_STB, SD_STATUS;
  logic [15:0] WR_DATA, RD_DATA, SD_DIN, SD_DOUT;
  logic        WR_READY, RD_READY, RD_VALID, MEM_READY, OVERFLOW, ERR;
  logic [1:0]  SD_CMD, SD_BANK;
  logic [12:0] SD_ROW;
  logic [8:0]  SD_COL;
  logic [24:0] COUNT;

  sdram_mem_scheduler #(.MAX_WORDS(1024), .ACCEPT_TO(8), .OP_TO(32)) dut (
    .CLK_48MHZ(CLK_48MHZ), .RESET(RESET), .WR_STB(WR_STB), .WR_DATA(WR_DATA),
    .WR_READY(WR_READY), .RD_STB(RD_STB), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
    .RD_VALID(RD_VALID), .SD_CMD(SD_CMD), .SD_BANK(SD_BANK), .SD_ROW(SD_ROW),
    .SD_COL(SD_COL), .SD_DIN(SD_DIN), .SD_STATUS(SD_STATUS), .SD_DOUT(SD_DOUT),
    .MEM_READY(MEM_READY), .COUNT(COUNT), .OVERFLOW(OVERFLOW), .ERR(ERR)
  );

  int          checks = 0;
  int          errors = 0;
  int          mode = 0;          // 0 forced status, 1 normal responder, 2 mute, 3 stuck busy
  logic        force_status = 1'b0;
  int          mstate = 0;
  int          bcnt = 0;
  int          n_cmd = 0;
  int          rv_cnt = 0;
  logic [1:0]  last_cmd = 2'd0;
  logic [23:0] last_addr = 24'd0;
  logic [1:0]  cmd_seq[$];
  logic [15:0] mem[int];

  initial begin
    CLK_48MHZ = 1'b0;
    forever #5 CLK_48MHZ = ~CLK_48MHZ;
  end

  // SDRAM interface model: raises SD_STATUS after seeing a command, drops it two cycles later.
  initial begin
    logic [23:0] a;
    SD_STATUS = 1'b0;
    SD_DOUT   = 16'd0;
    forever begin
      @(negedge CLK_48MHZ);
      if (RD_VALID) rv_cnt++;
      if (mode == 0) begin
        SD_STATUS = force_status;
        mstate    = 0;
      end else if (mode == 2) begin
        SD_STATUS = 1'b0;
      end else if (mstate == 0) begin
        if (SD_CMD != 2'd0) begin
          a         = {SD_BANK, SD_ROW, SD_COL};
          last_addr = a;
          last_cmd  = SD_CMD;
          cmd_seq.push_back(SD_CMD);
          n_cmd++;
          if (SD_CMD == 2'd2) mem[int'(a)] = SD_DIN;
          else SD_DOUT = mem.exists(int'(a)) ? mem[int'(a)] : 16'd0;
          SD_STATUS = 1'b1;
          mstate    = 1;
          bcnt      = 0;
        end
      end else if (mode == 1) begin
        bcnt++;
        if (bcnt == 2) begin
          SD_STATUS = 1'b0;
          mstate    = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_48MHZ);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!(WR_READY && RD_READY) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic do_wr(input logic [15:0] d);
    wait_ready("wr_ready_timeout");
    WR_STB = 1'b1; WR_DATA = d;
    tick();
    WR_STB = 1'b0;
  endtask

  task automatic do_rd();
    wait_ready("rd_ready_timeout");
    RD_STB = 1'b1;
    tick();
    RD_STB = 1'b0;
  endtask

  task automatic do_both(input logic [15:0] d);
    wait_ready("tie_ready_timeout");
    cmd_seq.delete();
    WR_STB = 1'b1; RD_STB = 1'b1; WR_DATA = d;
    tick();
    WR_STB = 1'b0; RD_STB = 1'b0;
    wait_ready("tie_done_timeout");
  endtask

  initial begin
    int rv0, n0, wp;
    RESET = 1'b0; WR_STB = 1'b0; RD_STB = 1'b0; WR_DATA = 16'd0;
    repeat (3) tick();
    chk("rst_mem_ready", {31'd0, MEM_READY}, 32'd0);
    chk("rst_count", {7'd0, COUNT}, 32'd0);
    chk("rst_flags", {28'd0, SD_CMD, OVERFLOW, ERR}, 32'd0);
    chk("rst_ready", {30'd0, WR_READY, RD_READY}, 32'd0);

    // Init handshake, with a write strobe that must be ignored.
    RESET = 1'b1;
    force_status = 1'b1;
    tick();
    WR_STB = 1'b1; WR_DATA = 16'h1234;
    tick();
    WR_STB = 1'b0;
    repeat (8) tick();
    chk("init_not_ready", {31'd0, MEM_READY}, 32'd0);
    force_status = 1'b0;
    repeat (2) tick();
    chk("init_ready", {31'd0, MEM_READY}, 32'd1);
    chk("init_count", {7'd0, COUNT}, 32'd0);
    chk("init_wr_ready", {31'd0, WR_READY}, 32'd1);

    // Single write then read at address 0.
    mode = 1;
    do_wr(16'hA5A5);
    wait_ready("w1_done");
    chk("w1_cmd", {30'd0, last_cmd}, 32'd2);
    chk("w1_addr", {8'd0, last_addr}, 32'd0);
    chk("w1_count", {7'd0, COUNT}, 32'd1);
    rv0 = rv_cnt;
    do_rd();
    wait_ready("r1_done");
    repeat (2) tick();
    chk("r1_cmd", {30'd0, last_cmd}, 32'd1);
    chk("r1_addr", {8'd0, last_addr}, 32'd0);
    chk("r1_data", {16'd0, RD_DATA}, 32'h0000A5A5);
    chk("r1_valid_pulses", rv_cnt - rv0, 32'd1);
    chk("r1_count", {7'd0, COUNT}, 32'd0);

    // Ties: after a read, the write goes first; after a write, the read goes first.
    do_wr(16'h0011); do_wr(16'h0022); do_wr(16'h0033); do_wr(16'h0044);
    do_rd();
    wait_ready("solo_rd_done");
    chk("solo_rd_data", {16'd0, RD_DATA}, 32'h00000011);
    chk("pre_tie_count", {7'd0, COUNT}, 32'd3);
    do_both(16'h0055);
    chk("tie1_n", cmd_seq.size(), 32'd2);
    chk("tie1_first", {30'd0, cmd_seq[0]}, 32'd2);
    chk("tie1_second", {30'd0, cmd_seq[1]}, 32'd1);
    chk("tie1_data", {16'd0, RD_DATA}, 32'h00000022);
    do_wr(16'h0066);
    do_both(16'h0077);
    chk("tie2_first", {30'd0, cmd_seq[0]}, 32'd1);
    chk("tie2_second", {30'd0, cmd_seq[1]}, 32'd2);
    chk("tie2_data", {16'd0, RD_DATA}, 32'h00000033);
    chk("tie2_addr", {8'd0, last_addr}, 32'd7);
    chk("tie2_count", {7'd0, COUNT}, 32'd4);

    // Accept timeout: SD_STATUS never rises.
    mode = 2;
    do_wr(16'hDEAD);
    tick();
    chk("to_cmd_start", {30'd0, SD_CMD}, 32'd2);
    repeat (7) tick();
    chk("to_cmd_held", {30'd0, SD_CMD}, 32'd2);
    tick();
    chk("to_cmd_dropped", {30'd0, SD_CMD}, 32'd0);
    tick();
    chk("to_err", {31'd0, ERR}, 32'd1);
    chk("to_wr_ready", {31'd0, WR_READY}, 32'd1);
    chk("to_count", {7'd0, COUNT}, 32'd4);

    // Fill to capacity (1024 words) crossing row boundary and wrap.
    mode = 1;
    for (int i = 0; i < 1020; i++) begin
      do_wr(16'(i));
      wait_ready("fill_done");
      wp = (8 + i) % 1024;
      if (wp == 511)  chk("addr_511", {8'd0, last_addr}, 32'h000001FF);
      if (wp == 512)  chk("addr_512_row1", {8'd0, last_addr}, 32'h00000200);
      if (wp == 1023) chk("addr_1023", {8'd0, last_addr}, 32'h000003FF);
      if (wp == 0)    chk("addr_wrap_0", {8'd0, last_addr}, 32'd0);
    end
    chk("full_count", {7'd0, COUNT}, 32'd1024);
    chk("full_no_ovf", {31'd0, OVERFLOW}, 32'd0);
    n0 = n_cmd;
    do_wr(16'hF00D);
    wait_ready("drop_done");
    chk("drop_ovf", {31'd0, OVERFLOW}, 32'd1);
    chk("drop_count", {7'd0, COUNT}, 32'd1024);
    chk("drop_no_cmd", n_cmd - n0, 32'd0);
    do_rd();
    wait_ready("full_rd_done");
    chk("full_rd_data", {16'd0, RD_DATA}, 32'h00000044);
    chk("full_rd_count", {7'd0, COUNT}, 32'd1023);
    do_wr(16'hBEEF);
    wait_ready("refill_done");
    chk("refill_addr", {8'd0, last_addr}, 32'd4);
    chk("refill_count", {7'd0, COUNT}, 32'd1024);

    // Reset while BUSY.
    mode = 3;
    do_rd();
    repeat (4) tick();
    chk("busy_cmd_clear", {30'd0, SD_CMD}, 32'd0);
    chk("busy_rd_pend", {31'd0, RD_READY}, 32'd0);
    RESET = 1'b0;
    #1;
    chk("mid_rst_ctrl", {27'd0, MEM_READY, OVERFLOW, ERR, SD_CMD}, 32'd0);
    chk("mid_rst_count", {7'd0, COUNT}, 32'd0);
    chk("mid_rst_addr", {8'd0, SD_BANK, SD_ROW, SD_COL}, 32'd0);
    chk("mid_rst_data", {SD_DIN, RD_DATA}, 32'd0);
    tick();
    RESET = 1'b1;
    mode = 0;
    force_status = 1'b1;
    repeat (3) tick();
    chk("reinit_wait", {31'd0, MEM_READY}, 32'd0);
    force_status = 1'b0;
    repeat (2) tick();
    chk("reinit_ready", {31'd0, MEM_READY}, 32'd1);
    chk("reinit_count", {7'd0, COUNT}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_mem_scheduler.md
Name: sdram_mem_scheduler

Overview:
- Sequences the SDRAM interface as a circular sample log shared by two requesters: the sensor logger (writes) and the telemetry downlink (reads).
- Owns the write and read pointers and the fill count, and maps linear pointers to bank/row/column.
- Drives the interface's command/address/data inputs and tracks its busy status handshake.
- Arbitrates fairly, with timeout and overflow reporting.

Parameters:
MAX_WORDS, 16777216, log capacity in 16-bit words; pointers wrap at MAX_WORDS-1 (must be 2..2^24)
ACCEPT_TO, 8, cycles allowed for SD_STATUS to rise after a command is presented
OP_TO, 32, cycles allowed for SD_STATUS to fall once busy

Ports:
CLK_48MHZ  in  1  system clock; all logic on rising edge
RESET  in  1  asynchronous active-low reset
WR_STB  in  1  one-cycle write request; WR_DATA captured on same edge
WR_DATA  in  16  sample to log
WR_READY  out  1  high when a new WR_STB will be accepted
RD_STB  in  1  one-cycle read request for oldest unread word
RD_READY  out  1  high when a new RD_STB will be accepted
RD_DATA  out  16  word read; valid with RD_VALID, held until next read completes
RD_VALID  out  1  one-cycle pulse when RD_DATA updated
SD_CMD  out  2  to interface command input: 0 idle, 1 read, 2 write
SD_BANK  out  2  bank = ptr[23:22]
SD_ROW  out  13  row = ptr[21:9]
SD_COL  out  9  column = ptr[8:0]
SD_DIN  out  16  write data to interface
SD_STATUS  in  1  interface busy flag
SD_DOUT  in  16  interface read data
MEM_READY  out  1  SDRAM initialization complete
COUNT  out  25  words currently stored (0..MAX_WORDS)
OVERFLOW  out  1  sticky: write dropped (log full or strobe while pending)
ERR  out  1  sticky: handshake timeout

Behaviour:
- Reset: all outputs, pointers, count, pending flags and sticky flags are 0. State INIT_WAIT. Last-served flag = read, so the write side wins the first tie.
- Request capture (any state after INIT_WAIT):
  - WR_STB with no write pending: latch WR_DATA and set wr_pend.
  - WR_STB with wr_pend already set: drop the data and set OVERFLOW.
  - RD_STB is handled the same way with rd_pend; a read strobe while pending is ignored with no flag.
  - WR_READY = MEM_READY & ~wr_pend. RD_READY = MEM_READY & ~rd_pend.
- INIT_WAIT: wait for SD_STATUS seen 1, then seen 0. Then set MEM_READY=1 and go to IDLE. MEM_READY stays 1 until reset. Strobes before MEM_READY are ignored.
- IDLE:
  - wr_pend with COUNT==MAX_WORDS: clear wr_pend, set OVERFLOW, no SDRAM op. This takes one cycle.
  - rd_pend with COUNT==0: rd_pend stays set until data exists.
  - Eligible = wr_pend with not full; rd_pend with not empty. If both are eligible, serve the side not served last (alternate). If one is eligible, serve it.
  - Load SD_BANK/ROW/COL from the chosen pointer, SD_DIN from the latched data, SD_CMD = 2 or 1. Go to ISSUE.
- ISSUE: hold SD_CMD and the address/data.
  - SD_STATUS==1: set SD_CMD=0 and go to BUSY.
  - ACCEPT_TO cycles elapse without that: go to FAIL.
- BUSY: address/data stay stable. When SD_STATUS==0, go to DONE. If OP_TO cycles elapse first, go to FAIL.
- DONE (1 cycle):
  - Write: wr_ptr advances, COUNT+1, wr_pend cleared.
  - Read: RD_DATA <= SD_DOUT, RD_VALID pulses, rd_ptr advances, COUNT-1, rd_pend cleared.
  - Update the last-served flag, then go to IDLE.
- FAIL (1 cycle): SD_CMD=0, ERR set, the served pending flag is cleared, pointers and COUNT are unchanged, then go to IDLE.
- Pointer advance: ptr==MAX_WORDS-1 wraps to 0; otherwise ptr+1. Address outputs always come from the 24-bit pointer.
- New strobes in the same cycle as a DONE that clears the same pend flag are accepted (new pend is set). COUNT is never modified by both sides in one cycle.
- Reset asserted mid-operation returns immediately to the reset state. Any in-flight SDRAM op is abandoned and the logged contents are considered lost.

Test Plan:
- Init: SD_STATUS held 1 for 10 cycles then 0 -> MEM_READY=1 one to two cycles later. WR_STB before that is ignored and COUNT=0.
- Single write then read:
  - Write 0xA5A5 -> SD_CMD=2 at bank 0 row 0 col 0, then COUNT=1.
  - RD_STB -> SD_CMD=1 at the same address. SD_DOUT=0xA5A5 returns RD_DATA=0xA5A5 with one RD_VALID pulse, and COUNT=0.
- Simultaneous WR_STB and RD_STB with COUNT=3 -> the write is served first after reset, then the read. Repeated ties alternate write/read.
- MAX_WORDS=4: five writes, no reads -> COUNT=4, fifth write dropped, OVERFLOW=1. A read then a write -> the write goes to col 0 (wrapped).
- SD_STATUS never rises after command -> SD_CMD returns to 0 after ACCEPT_TO cycles, ERR=1, COUNT unchanged, WR_READY=1 again.
- Pointer 511 -> 512 mapping: the 513th write appears at row 1 col 0. RESET pulled low during BUSY -> all outputs 0 and INIT_WAIT re-entered.
